lif_neuron: RTL and testbench
=============================

# lif_neuron

Leaky integrate-and-fire (LIF) neuron packaged as a Tiny Tapeout user tile.
- An 8-bit input current is integrated into an 8-bit membrane potential that leaks by a right shift every clock.
- The neuron fires a spike when the potential reaches a threshold; the potential then resets to zero.
- The tile exposes the potential on the dedicated outputs and the spike on one bidirectional pin.

## Interface
Parameters:
- THRESHOLD, 200: firing level; spike is asserted while state ≥ THRESHOLD.
- LEAK_SHIFT, 1: leak is state >> LEAK_SHIFT; legal range 1–7.
- REFRACT_CYCLES, 2: extra zero-hold cycles after a spike (only with LIF_REFRACTORY_EN); legal range 1–15.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tile enable; state is held while low.
- ui_in  in  8  input current, unsigned.
- uio_in  in  8  unused, ignored.
- uo_out  out  8  membrane potential (state).
- uio_out  out  8  bit7 = spike; bits 6:0 = 0.
- uio_oe  out  8  constant 8'h80 (only uio[7] is driven).

## Operation
- spike = (state ≥ THRESHOLD). This is combinational from the state register; no input feeds it directly.
- Next state, evaluated at each clk rising edge when ena=1:
  - if spike: state ← 0, and the current on that edge is discarded.
  - else: sum = ui_in + (state >> LEAK_SHIFT), computed 9 bits wide. state ← (sum > 255) ? 255 : sum[7:0] (saturating, never wraps).
- ena=0: state and the refractory counter hold. spike still reflects the held state.
- Constant current I with no spike converges to a fixed point. With LEAK_SHIFT=1 and THRESHOLD=200:
  - I ≤ 100: state converges to ≤ 199 and never fires.
  - I ≥ 101: the neuron fires periodically.

## Timing
- Reset: state=0, spike=0, uo_out=0, uio_out=0, refractory counter=0. uio_oe=8'h80 always, including during reset.
- Latency: ui_in sampled at edge N appears in uo_out after edge N. spike is valid in the same cycle as the state that causes it.
- The spike pulse lasts one cycle per threshold crossing, since state is 0 after the following edge.
- Reset asserted mid-integration clears state and spike immediately (asynchronously).
- Reset releasing with ena=1 starts integration at the next edge.

## Configuration
- LIF_REFRACTORY_EN defined:
  - the edge that clears a spiking state also loads counter ← REFRACT_CYCLES.
  - while counter > 0, each enabled edge keeps state=0, ignores ui_in, and decrements the counter.
  - integration resumes on the edge where counter = 0.
- LIF_REFRACTORY_EN undefined: no counter hardware; integration resumes on the edge immediately after the reset-to-zero.

## Structure
- Shared package lif_pkg holds:
  - the widths: STATE_W=8, SUM_W=9;
  - the default THRESHOLD, LEAK_SHIFT and REFRACT_CYCLES constants;
  - a saturate function.
- One sub-module, lif_core: ports current, clk, rst_n, en, spike, state. It holds the register, the leak, the adder and saturation, the threshold compare, and the refractory logic.
- lif_neuron is the tile wrapper only: pin mapping plus the constant uio_oe.

## Test plan
- Reset: hold rst_n=0 with ui_in=255 → uo_out=0, uio_out=0, uio_oe=8'h80. Assert rst_n mid-run → outputs return to 0 immediately.
- Sub-threshold: ui_in=100 from state 0 → state 100,150,175,187,193,196,198,199,199…; spike never asserted.
- Just above threshold: ui_in=101 → state 101,151,176,189,195,198,200 with spike=1 on the 200 cycle → next state 0, then the sequence repeats.
- Saturation: ui_in=255 from state 0 → state 255 (no wrap), spike=1 → 0 → 255…
  - Without the macro: spike period 2.
  - With LIF_REFRACTORY_EN (REFRACT_CYCLES=2): sequence 255,0,0,0,255, period 4.
- Enable hold: ui_in=60 for 2 cycles (state 60, 90), then ena=0 for 5 cycles → state stays 90. ena=1 → state 105.
- Sweep: ui_in = 0..255, one value per cycle after reset → check every cycle against a reference model computing the next state and spike.

Source files
------------

// File: rtl/lif_pkg.sv
// Purpose : shared widths, default tuning constants and the saturation helper for the LIF neuron.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package lif_pkg;

    localparam int STATE_W = 8;
    localparam int SUM_W   = 9;
    localparam int REFRACT_W = 4;

    localparam int DEF_THRESHOLD      = 200;
    localparam int DEF_LEAK_SHIFT     = 1;
    localparam int DEF_REFRACT_CYCLES = 2;

    // Clamp a 9-bit sum to the 8-bit state range instead of wrapping.
    function automatic logic [STATE_W-1:0] saturate(input logic [SUM_W-1:0] sum);
        return sum[SUM_W-1] ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
    endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Purpose : Tiny Tapeout tile pin bundle (enable, dedicated and bidirectional pins).
// Latency : n/a (wires only).
// Backpressure: none; the tile has no flow control.
// Ports   : ena, ui_in, uio_in driven by the harness; uo_out, uio_out, uio_oe driven by the tile.
interface lif_neuron_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/lif_core.sv
// Purpose : leaky integrate-and-fire core: leak, saturating add, threshold compare, optional refractory hold.
// Latency : current sampled on an enabled edge shows in state after that edge; spike is combinational from state.
// Backpressure: none; en=0 freezes state and refractory counter.
// Ports   : clk, rst_n (async active-low), en, current[7:0] in; spike, state[7:0] out.
// Config  : LIF_REFRACTORY_EN adds a REFRACT_CYCLES zero-hold counter after each spike.
module lif_core
    import lif_pkg::*;
#(
    parameter int THRESHOLD      = DEF_THRESHOLD,
    parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
    parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [STATE_W-1:0] current,
    output logic               spike,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0]   THRESH_V  = STATE_W'(THRESHOLD);
    localparam logic [REFRACT_W-1:0] REFRACT_V = REFRACT_W'(REFRACT_CYCLES);

    logic [STATE_W-1:0] leaked;
    logic [SUM_W-1:0]   sum;

    assign leaked = state >> LEAK_SHIFT;
    // Nine bits wide so the carry is visible to saturate().
    assign sum    = {1'b0, current} + {1'b0, leaked};
    assign spike  = (state >= THRESH_V);

`ifdef LIF_REFRACTORY_EN
    logic [REFRACT_W-1:0] refract;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= '0;
            refract <= '0;
        end else if (en) begin
            if (spike) begin
                // The firing edge both clears the potential and arms the hold-off.
                state   <= '0;
                refract <= REFRACT_V;
            end else if (refract != '0) begin
                state   <= '0;
                refract <= refract - 1'b1;
            end else begin
                state   <= saturate(sum);
            end
        end
    end
`else
    logic unused_refract;
    assign unused_refract = ^REFRACT_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (en) begin
            // Current arriving on the firing edge is discarded.
            state <= spike ? '0 : saturate(sum);
        end
    end
`endif

endmodule

// File: rtl/lif_neuron.sv
// Purpose : Tiny Tapeout tile wrapper for lif_core: potential on uo_out, spike on uio[7].
// Latency : one clock from ui_in to uo_out; spike is valid alongside the state that causes it.
// Backpressure: none; ena=0 holds the neuron.
// Ports   : clk, rst_n (async active-low), pins (lif_neuron_if.slave: ena, ui_in, uio_in, uo_out, uio_out, uio_oe).
// Config  : LIF_REFRACTORY_EN enables the post-spike refractory period inside lif_core.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int THRESHOLD      = DEF_THRESHOLD,
    parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
    parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    lif_neuron_if.slave  pins
);

    logic               spike;
    logic [STATE_W-1:0] state;

    lif_core #(
        .THRESHOLD      (THRESHOLD),
        .LEAK_SHIFT     (LEAK_SHIFT),
        .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pins.ena),
        .current (pins.ui_in),
        .spike   (spike),
        .state   (state)
    );

    assign pins.uo_out  = state;
    assign pins.uio_out = {spike, 7'b0};
    // Only uio[7] is an output; constant, so it holds through reset too.
    assign pins.uio_oe  = 8'h80;

    logic unused_uio;
    assign unused_uio = ^pins.uio_in;

endmodule

// File: tb/tb_lif_neuron.sv
// Purpose : self-checking bench for lif_neuron against an arithmetic reference model.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lif_neuron;

    localparam int THR  = 200;
    localparam int LEAK = 1;
    localparam int REFR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lif_neuron_if pins();

    lif_neuron #(
        .THRESHOLD      (THR),
        .LEAK_SHIFT     (LEAK),
        .REFRACT_CYCLES (REFR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_state = 0;
    int m_refr  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: fire-and-clear above threshold, otherwise leak by division and clamp at 255.
    function automatic void model_edge(input int cur, input bit en);
        int s;
        if (!en) return;
        if (m_state >= THR) begin
            m_state = 0;
`ifdef LIF_REFRACTORY_EN
            m_refr = REFR;
`endif
        end else if (m_refr > 0) begin
            m_state = 0;
            m_refr--;
        end else begin
            s = cur + m_state / (2 ** LEAK);
            m_state = (s > 255) ? 255 : s;
        end
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_refr  = 0;
    endfunction

    // Entered and left just after a falling edge.
    task automatic step(input string tag, input int cur, input bit en);
        pins.ui_in  = 8'(cur);
        pins.ena    = en;
        pins.uio_in = 8'($urandom);
        @(posedge clk);
        model_edge(cur, en);
        @(negedge clk);
        chk({tag, "_state"}, pins.uo_out, m_state);
        chk({tag, "_spike"}, pins.uio_out, (m_state >= THR) ? 8'h80 : 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int sub_tbl[10] = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};
    int abv_tbl[7]  = '{101, 151, 176, 189, 195, 198, 200};
`ifdef LIF_REFRACTORY_EN
    int sat_tbl[8]  = '{255, 0, 0, 0, 255, 0, 0, 0};
`else
    int sat_tbl[8]  = '{255, 0, 255, 0, 255, 0, 255, 0};
`endif

    initial begin
        pins.ena    = 1'b1;
        pins.ui_in  = 8'd255;
        pins.uio_in = 8'h00;
        rst_n       = 1'b0;

        // Reset held with full input current.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uo_out", pins.uo_out, 0);
        chk("rst_uio_out", pins.uio_out, 0);
        chk("rst_uio_oe", pins.uio_oe, 8'h80);
        rst_n = 1'b1;

        // Sub-threshold: converges to 199, never fires.
        for (int i = 0; i < 10; i++) begin
            step("sub", 100, 1'b1);
            chk("sub_tbl", pins.uo_out, sub_tbl[i]);
            chk("sub_nospike", pins.uio_out, 0);
        end

        // Asynchronous reset mid-integration.
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", pins.uo_out, 0);
        chk("async_rst_uio_out", pins.uio_out, 0);
        chk("async_rst_uio_oe", pins.uio_oe, 8'h80);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Just above threshold: fires on 200, then restarts.
        for (int i = 0; i < 7; i++) begin
            step("abv", 101, 1'b1);
            chk("abv_tbl", pins.uo_out, abv_tbl[i]);
        end
        chk("abv_fire", pins.uio_out, 8'h80);
        step("abv_clear", 101, 1'b1);
        chk("abv_zero", pins.uo_out, 0);
        for (int i = 0; i < 20; i++) step("abv_run", 101, 1'b1);

        // Saturation: no wrap, periodic spiking.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("sat", 255, 1'b1);
            chk("sat_tbl", pins.uo_out, sat_tbl[i]);
        end

        // Enable hold.
        do_reset();
        step("hold", 60, 1'b1);
        chk("hold_60", pins.uo_out, 60);
        step("hold", 60, 1'b1);
        chk("hold_90", pins.uo_out, 90);
        for (int i = 0; i < 5; i++) begin
            step("hold_off", $urandom_range(0, 255), 1'b0);
            chk("hold_keep", pins.uo_out, 90);
        end
        step("hold", 60, 1'b1);
        chk("hold_105", pins.uo_out, 105);

        // Sweep every input value once.
        do_reset();
        for (int v = 0; v < 256; v++) step("sweep", v, 1'b1);

        // Random current and enable, with one asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                chk("rand_rst_uo_out", pins.uo_out, 0);
                chk("rand_rst_uio_out", pins.uio_out, 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("rand",
                 ($urandom_range(0, 3) == 0) ? $urandom_range(180, 255) : $urandom_range(0, 255),
                 $urandom_range(0, 7) != 0);
        end
        chk("final_uio_oe", pins.uio_oe, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
